// File: rtl/uberclock_pkg.sv
// Shared definitions for the uberclock sweep scheduler: datapath width
// defaults and the sweep state encoding.
package uberclock_pkg;

  localparam int PW_DEF = 19;  // NCO phase-increment width
  localparam int DW_DEF = 16;  // decimated sample width (signed)
  localparam int CW_DEF = 16;  // step / settle / dwell counter width
  localparam int AW_DEF = 34;  // accumulator width, >= DW + 1 + CW

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DWELL  = 3'd2,
    ST_POST   = 3'd3,
    ST_FINISH = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/sweep_absacc.sv
// |x|+|y| magnitude estimate feeding a clearable accumulator. acc_nxt is
// the value the accumulator would take with this cycle's sample added, so
// the controller can capture a point's final sum on its last strobe.
module sweep_absacc #(
  parameter int DW = 16,
  parameter int AW = 34
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data_x,
  input  logic [DW-1:0] data_y,
  output logic [AW-1:0] acc,
  output logic [AW-1:0] acc_nxt
);

  localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

  logic [DW:0]   x_ext;
  logic [DW:0]   y_ext;
  logic [DW:0]   abs_x;
  logic [DW:0]   abs_y;
  logic [DW+1:0] abs_sum;

  // Magnitudes are formed at DW+1 bits so |-2^(DW-1)| is exact.
  always_comb begin
    x_ext   = {data_x[DW-1], data_x};
    y_ext   = {data_y[DW-1], data_y};
    abs_x   = x_ext[DW] ? (~x_ext + ONE) : x_ext;
    abs_y   = y_ext[DW] ? (~y_ext + ONE) : y_ext;
    abs_sum = {1'b0, abs_x} + {1'b0, abs_y};
    acc_nxt = acc + {{(AW-DW-2){1'b0}}, abs_sum};
  end

  // Accumulator: clear has priority over accumulate.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler: steps the downconversion NCO increment through
// a programmed list, discards a settle window, accumulates |x|+|y| over a
// dwell window and hands each point's result to the CPU via a valid/ack slot.
module sweep_ctrl
  import uberclock_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [PW-1:0] cfg_start_inc,
  input  logic [PW-1:0] cfg_step_inc,
  input  logic [CW-1:0] cfg_num_steps,
  input  logic [CW-1:0] cfg_settle,
  input  logic [CW-1:0] cfg_dwell,
  input  logic          start,
  input  logic          abort,
  input  logic          ce_down,
  input  logic [DW-1:0] data_x,
  input  logic [DW-1:0] data_y,
  output logic [PW-1:0] phase_inc_down,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  input  logic          res_ack,
  output logic [CW-1:0] res_index,
  output logic [PW-1:0] res_inc,
  output logic [AW-1:0] res_acc
);

  localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  sweep_state_e  state;
  logic [PW-1:0] step_q;
  logic [CW-1:0] steps_q;
  logic [CW-1:0] settle_q;
  logic [CW-1:0] dwell_q;
  logic [CW-1:0] index;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          slot_free;
  logic          last_strobe;
  logic          complete_now;
  logic          last_point;
  logic          acc_clr;
  logic          acc_en;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [AW-1:0] point_sum;
  sweep_state_e  point_entry;

  // Point-completion and accumulator control decoded from current state.
  always_comb begin
    accept       = (state == ST_IDLE) && start && !abort;
    slot_free    = !res_valid || res_ack;
    last_strobe  = (state == ST_DWELL) && ce_down && (cnt == dwell_q - ONE_CW);
    complete_now = (last_strobe || (state == ST_POST)) && slot_free && !abort;
    last_point   = (index == steps_q - ONE_CW);
    acc_en       = (state == ST_DWELL) && ce_down;
    acc_clr      = accept || (complete_now && !last_point);
    // In POST the sum is already complete in the register; on the final
    // dwell strobe it still needs this cycle's sample folded in.
    point_sum    = (state == ST_POST) ? acc : acc_nxt;
    point_entry  = (settle_q == '0) ? ST_DWELL : ST_SETTLE;
  end

  sweep_absacc #(
    .DW (DW),
    .AW (AW)
  ) u_absacc (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .data_x  (data_x),
    .data_y  (data_y),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  // Sweep FSM, config latch, counters and result slot.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      step_q         <= '0;
      steps_q        <= '0;
      settle_q       <= '0;
      dwell_q        <= '0;
      index          <= '0;
      cnt            <= '0;
      phase_inc_down <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      res_valid      <= 1'b0;
      res_index      <= '0;
      res_inc        <= '0;
      res_acc        <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (res_ack) begin
        res_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            step_q         <= cfg_step_inc;
            steps_q        <= cfg_num_steps;
            settle_q       <= cfg_settle;
            dwell_q        <= (cfg_dwell == '0) ? ONE_CW : cfg_dwell;
            index          <= '0;
            cnt            <= '0;
            phase_inc_down <= cfg_start_inc;
            busy           <= 1'b1;
            done           <= 1'b0;
            if (cfg_num_steps == '0) begin
              state <= ST_FINISH;
            end else if (cfg_settle == '0) begin
              state <= ST_DWELL;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (ce_down) begin
            if (cnt == settle_q - ONE_CW) begin
              cnt   <= '0;
              state <= ST_DWELL;
            end else begin
              cnt <= cnt + ONE_CW;
            end
          end
        end
        ST_DWELL: begin
          if (ce_down) begin
            if (last_strobe) begin
              cnt <= '0;
              if (!slot_free) begin
                state <= ST_POST;
              end
            end else begin
              cnt <= cnt + ONE_CW;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: ;
      endcase

      // Result load and advance to the next point, from DWELL or POST.
      if (complete_now) begin
        res_valid <= 1'b1;
        res_index <= index;
        res_inc   <= phase_inc_down;
        res_acc   <= point_sum;
        if (last_point) begin
          state <= ST_FINISH;
        end else begin
          index          <= index + ONE_CW;
          phase_inc_down <= phase_inc_down + step_q;
          state          <= point_entry;
        end
      end
    end
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep scheduler for the downconversion path. It drives `phase_inc_down` through a programmed list of NCO increments. At each point it discards a settle window of decimated samples, then accumulates |x|+|y| over a dwell window of `ce_down` strobes. Each point's result goes to the CPU through a valid/ack register slot. It sits between the CSR bank and the uberclock datapath, replacing the static `phase_inc_down` CSR while a sweep runs.

## Interface
- `PW`, 19, phase-increment width (matches datapath NCO)
- `DW`, 16, decimated sample width (signed)
- `CW`, 16, width of step/settle/dwell counters
- `AW`, 34, accumulator width; must be ≥ DW+1+CW
---
- `sys_clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cfg_start_inc`  in  PW  increment of first point
- `cfg_step_inc`  in  PW  increment added per point (mod 2^PW)
- `cfg_num_steps`  in  CW  number of points; 0 = empty sweep
- `cfg_settle`  in  CW  `ce_down` strobes discarded after each increment change
- `cfg_dwell`  in  CW  strobes accumulated per point; 0 treated as 1
- `start`  in  1  single-cycle sweep request
- `abort`  in  1  single-cycle cancel
- `ce_down`  in  1  decimated-sample strobe
- `data_x`, `data_y`  in  DW  signed decimated I/Q, valid when `ce_down`=1
- `phase_inc_down`  out  PW  increment to downconversion accumulator
- `busy`  out  1  sweep in progress
- `done`  out  1  sticky; set at normal completion, cleared by next accepted `start`
- `res_valid`  out  1  result slot full
- `res_ack`  in  1  CPU consumed result
- `res_index`  out  CW  point number, 0-based
- `res_inc`  out  PW  increment used for the point
- `res_acc`  out  AW  unsigned Σ(|x|+|y|) over dwell

## Operation
- Config is latched on accepted `start`. Changing the cfg inputs mid-sweep has no effect.
- States and transitions:
  - IDLE: `start` (with `abort`=0) → SETTLE.
    - `phase_inc_down` ← `cfg_start_inc`; busy=1; done=0; index=0.
    - If `cfg_num_steps`=0, go to FINISH instead.
  - SETTLE: count `ce_down` strobes.
    - When the count reaches `cfg_settle`, go to DWELL (immediately if `cfg_settle`=0).
    - Accumulator cleared on entry.
  - DWELL: each `ce_down` adds |data_x|+|data_y| to the accumulator.
    - |−2^(DW−1)| = 2^(DW−1), computed at DW+1 bits with no saturation.
    - On the dwell-th strobe the point completes.
  - Point completion:
    - If the slot is free (`res_valid`=0, or `res_ack`=1 this cycle), load the result registers.
    - If more points remain: index+1, `phase_inc_down` += step (wraps), → SETTLE.
    - Otherwise → FINISH.
    - If the slot is occupied: → POST, holding the sum. `ce_down` is ignored in POST.
  - POST: on the first cycle the slot is free, load the result and take the same next-point/FINISH branch.
  - FINISH: done=1, busy=0, → IDLE. `phase_inc_down` holds the last point's increment.
- `start` while busy is ignored.
- `abort` in any state → IDLE next cycle: busy=0, done unchanged, `res_valid` cleared, `phase_inc_down` held. `abort` wins over a simultaneous `start`.
- `res_ack` with `res_valid`=0 is ignored. The same-cycle ack plus new load gives `res_valid` staying 1 with new data.

## Timing
- Reset values: `phase_inc_down`=0, `busy`=0, `done`=0, `res_valid`=0, and `res_index`/`res_inc`/`res_acc`=0.
- `start` at edge N → `phase_inc_down`, `busy` updated at edge N+1.
- Result registers and the next `phase_inc_down` update on the edge after the final dwell strobe (1-cycle latency).
- The first settle strobe counted is the first `ce_down` on or after the cycle following the increment change.
- Downstream CORDIC/filter group delay is covered by `cfg_settle`; no other compensation.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `uberclock_pkg`: sweep state enum (IDLE, SETTLE, DWELL, POST, FINISH), and the PW/DW defaults.
- One sub-module, `sweep_absacc`: abs(x)+abs(y) adder plus a clearable AW-bit accumulator with enable.
- FSM and counters stay in `sweep_ctrl`.

## Test plan
- Basic sweep: start=1000, step=500, steps=3, settle=2, dwell=4, x=100, y=−50 constant, `ce_down` every 8 cycles, immediate ack → results (0,1000,600), (1,1500,600), (2,2000,600); done=1; `phase_inc_down`=2000.
- Backpressure: same sweep, ack withheld 100 cycles after the first result → FSM in POST, later strobes ignored; results still exact and in order; no loss.
- Extremes: x=y=−32768, dwell=65535 → `res_acc`=65536·65535 = 4294901760, no overflow; step wraps: start=2^19−1, step=2 → second point inc=1.
- Degenerate config: steps=0 → done one cycle after entering FINISH, no result; dwell=0 → one sample per point; settle=0 → accumulation from first strobe.
- Abort mid-DWELL with `res_valid`=1 → next cycle busy=0, `res_valid`=0, done=0; new start then runs cleanly.
- Async reset asserted mid-sweep → all outputs return to reset values immediately, without a clock edge; start ignored while `rst_n`=0.
